// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 encodings for
// loads and stores, byte-enable patterns, the LSU FSM state type and the
// alignment-check helper used by the top level.
package mem_stage_lsu_pkg;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Byte-enable base patterns (shifted into place by the byte offset)
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } lsu_state_e;

  // Halfword accesses need addr[0]=0, words need addr[1:0]=0; encodings with
  // no defined access size (011/110/111) are always treated as misaligned.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    case (f3)
      3'b001, 3'b101:         is_misaligned = addr_lo[0];
      3'b010:                 is_misaligned = |addr_lo;
      3'b011, 3'b110, 3'b111: is_misaligned = 1'b1;
      default:                is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU (purely combinational).
//   is_store   : current op is a store (selects store be/wdata, else load be)
//   func3      : access size / sign
//   addr_lo    : effective address bits [1:0]
//   store_data : rs2 value to be written
//   load_rdata : raw word returned by data memory
//   be, wdata  : byte enables and lane-replicated write data for the request
//   load_data  : extracted and sign/zero-extended load result
module lsu_align
  import mem_stage_lsu_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Stores replicate the datum across every lane it could land in, so the
  // memory only has to honour the byte enables.
  always_comb begin
    be    = BE_WORD;
    wdata = '0;
    if (is_store) begin
      case (func3[1:0])
        2'b00: begin
          be    = BE_BYTE << addr_lo;
          wdata = {4{store_data[7:0]}};
        end
        2'b01: begin
          be    = BE_HALF << {addr_lo[1], 1'b0};
          wdata = {2{store_data[15:0]}};
        end
        default: begin
          be    = BE_WORD;
          wdata = store_data;
        end
      endcase
    end
  end

  always_comb begin
    case (addr_lo)
      2'd0:    sel_byte = load_rdata[7:0];
      2'd1:    sel_byte = load_rdata[15:8];
      2'd2:    sel_byte = load_rdata[23:16];
      default: sel_byte = load_rdata[31:24];
    endcase
    sel_half = addr_lo[1] ? load_rdata[31:16] : load_rdata[15:0];
  end

  always_comb begin
    case (func3)
      F3_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_LBU:  load_data = {24'b0, sel_byte};
      F3_LH:   load_data = {{16{sel_half[15]}}, sel_half};
      F3_LHU:  load_data = {16'b0, sel_half};
      default: load_data = load_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage with load/store unit and MEM/WB register.
//   clk, rst             : clock, synchronous active-high reset
//   me_*                 : EX/MEM register contents (address, store data, control)
//   dmem_req/we/addr/wdata/be, dmem_ready : data-memory request channel
//   dmem_rvalid/rdata    : data-memory load response
//   mem_stall            : freeze IF..EX/MEM this cycle
//   wb_*                 : registered MEM/WB outputs
// Stores complete on acceptance; loads wait in RESP for rvalid. Misaligned
// ops never reach memory and are reported through wb_mem_exc.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] me_alu_o,
  input  logic [XLEN-1:0] me_regs_data2,
  input  logic [4:0]      me_rd,
  input  logic            me_mem_read,
  input  logic            me_mem_write,
  input  logic            me_mem2reg,
  input  logic            me_regs_write,
  input  logic [2:0]      me_func3_code,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ready,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            mem_stall,
  output logic [XLEN-1:0] wb_alu_o,
  output logic [XLEN-1:0] wb_load_data,
  output logic [4:0]      wb_rd,
  output logic            wb_mem2reg,
  output logic            wb_regs_write,
  output logic            wb_mem_exc
);

  lsu_state_e      state, state_nxt;
  logic            op_valid, op_mis, op_go;
  logic [XLEN-1:0] load_fmt;

  assign op_valid = me_mem_read | me_mem_write;
  assign op_mis   = op_valid & is_misaligned(me_func3_code, me_alu_o[1:0]);
  assign op_go    = op_valid & ~op_mis;

  assign dmem_we   = me_mem_write;
  assign dmem_addr = {me_alu_o[XLEN-1:2], 2'b00};

  lsu_align u_align (
    .is_store   (me_mem_write),
    .func3      (me_func3_code),
    .addr_lo    (me_alu_o[1:0]),
    .store_data (me_regs_data2),
    .load_rdata (dmem_rdata),
    .be         (dmem_be),
    .wdata      (dmem_wdata),
    .load_data  (load_fmt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // RESP only listens to rvalid, so a response arriving alongside ready (or
  // a stray one after reset) cannot complete anything.
  always_comb begin
    state_nxt = state;
    dmem_req  = 1'b0;
    mem_stall = 1'b0;
    case (state)
      ST_IDLE, ST_REQ: begin
        if (op_go) begin
          dmem_req = 1'b1;
          if (!dmem_ready) begin
            mem_stall = 1'b1;
            state_nxt = ST_REQ;
          end else if (me_mem_write) begin
            state_nxt = ST_IDLE;
          end else begin
            mem_stall = 1'b1;
            state_nxt = ST_RESP;
          end
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (dmem_rvalid) state_nxt = ST_IDLE;
        else             mem_stall = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // MEM/WB register: a stalled edge becomes a bubble with data fields held.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_alu_o      <= '0;
      wb_load_data  <= '0;
      wb_rd         <= '0;
      wb_mem2reg    <= 1'b0;
      wb_regs_write <= 1'b0;
      wb_mem_exc    <= 1'b0;
    end else if (mem_stall) begin
      wb_mem2reg    <= 1'b0;
      wb_regs_write <= 1'b0;
      wb_mem_exc    <= 1'b0;
    end else begin
      wb_alu_o      <= me_alu_o;
      wb_load_data  <= (me_mem_read & ~op_mis) ? load_fmt : '0;
      wb_rd         <= me_rd;
      wb_mem2reg    <= me_mem2reg;
      wb_regs_write <= me_regs_write & ~op_mis;
      wb_mem_exc    <= op_mis;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Testbench for mem_stage_lsu: a transaction driver plays each op against a
// chosen ready/rvalid timeline, a reference model derived from access-size
// arithmetic predicts every output, and one compare process checks the DUT
// on the falling edge of every cycle.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] me_alu_o, me_regs_data2;
  logic [4:0]  me_rd;
  logic        me_mem_read, me_mem_write, me_mem2reg, me_regs_write;
  logic [2:0]  me_func3_code;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic [31:0] wb_alu_o, wb_load_data;
  logic [4:0]  wb_rd;
  logic        wb_mem2reg, wb_regs_write, wb_mem_exc;

  always #5 clk = ~clk;

  mem_stage_lsu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .me_alu_o(me_alu_o), .me_regs_data2(me_regs_data2), .me_rd(me_rd),
    .me_mem_read(me_mem_read), .me_mem_write(me_mem_write),
    .me_mem2reg(me_mem2reg), .me_regs_write(me_regs_write),
    .me_func3_code(me_func3_code),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall),
    .wb_alu_o(wb_alu_o), .wb_load_data(wb_load_data), .wb_rd(wb_rd),
    .wb_mem2reg(wb_mem2reg), .wb_regs_write(wb_regs_write), .wb_mem_exc(wb_mem_exc)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Expectations for the current cycle
  logic        chk_en = 1'b0, chk_ctl = 1'b0;
  logic        e_req, e_stall, e_we;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_be;
  // Model of the MEM/WB register
  logic [31:0] m_alu, m_ld;
  logic [4:0]  m_rd;
  logic        m_m2r, m_rw, m_exc;
  bit          cur_mis;
  // Observation counters for directed scenarios
  int          stall_cnt, req_cnt;
  logic [3:0]  seen_be;
  logic [31:0] seen_wdata;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic int acc_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit m_misaligned(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    return (a % acc_size(f3)) != 0;
  endfunction

  function automatic logic [31:0] m_fmt(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] d);
    int sz;
    logic [31:0] v;
    sz = acc_size(f3);
    if (sz == 4) return d;
    v = (d >> ((a % 4) * 8)) & ((32'd1 << (sz * 8)) - 1);
    if (!f3[2] && v >= (32'd1 << (sz * 8 - 1))) v = v - (32'd1 << (sz * 8));
    return v;
  endfunction

  function automatic logic [3:0] m_be(input bit wr, input logic [2:0] f3, input logic [31:0] a);
    int sz, m;
    if (!wr) return 4'hF;
    sz = acc_size(f3);
    if (sz == 4) return 4'hF;
    m = ((1 << sz) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input bit wr, input logic [2:0] f3, input logic [31:0] d);
    int sz;
    if (!wr) return 32'h0;
    sz = acc_size(f3);
    if (sz == 1) return (d & 32'hFF) * 32'h01010101;
    if (sz == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      if (chk_ctl) begin
        check("dmem_req", {31'b0, dmem_req}, {31'b0, e_req});
        check("mem_stall", {31'b0, mem_stall}, {31'b0, e_stall});
        if (e_req) begin
          check("dmem_we", {31'b0, dmem_we}, {31'b0, e_we});
          check("dmem_addr", dmem_addr, e_addr);
          check("dmem_be", {28'b0, dmem_be}, {28'b0, e_be});
          check("dmem_wdata", dmem_wdata, e_wdata);
        end
      end
      check("wb_alu_o", wb_alu_o, m_alu);
      check("wb_load_data", wb_load_data, m_ld);
      check("wb_rd", {27'b0, wb_rd}, {27'b0, m_rd});
      check("wb_mem2reg", {31'b0, wb_mem2reg}, {31'b0, m_m2r});
      check("wb_regs_write", {31'b0, wb_regs_write}, {31'b0, m_rw});
      check("wb_mem_exc", {31'b0, wb_mem_exc}, {31'b0, m_exc});
    end
    if (mem_stall) stall_cnt++;
    if (dmem_req) begin
      req_cnt++;
      seen_be    = dmem_be;
      seen_wdata = dmem_wdata;
    end
  end

  // Advance one edge and update the MEM/WB model from what was presented.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_alu = 0; m_ld = 0; m_rd = 0; m_m2r = 0; m_rw = 0; m_exc = 0;
    end else if (e_stall) begin
      m_m2r = 0; m_rw = 0; m_exc = 0;
    end else begin
      m_alu = me_alu_o;
      m_rd  = me_rd;
      m_m2r = me_mem2reg;
      m_rw  = me_regs_write && !cur_mis;
      m_exc = cur_mis;
      m_ld  = (me_mem_read && !cur_mis) ? m_fmt(me_func3_code, me_alu_o, dmem_rdata) : 32'h0;
    end
    #1;
  endtask

  // Drive one op. rdy_dly = cycles with ready low before acceptance,
  // rv_dly = cycles from acceptance to the rvalid cycle (loads, >= 1).
  task automatic do_op(input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data,
                       input int rdy_dly, input int rv_dly, input logic [31:0] rdata,
                       input logic [4:0] rdn, input bit m2r, input bit rw);
    bit go;
    me_mem_read = rd; me_mem_write = wr; me_func3_code = f3;
    me_alu_o = addr; me_regs_data2 = data; me_rd = rdn;
    me_mem2reg = m2r; me_regs_write = rw;
    cur_mis = (rd || wr) && m_misaligned(f3, addr);
    go      = (rd || wr) && !cur_mis;
    e_we = wr; e_addr = addr & 32'hFFFF_FFFC;
    e_be = m_be(wr, f3, addr); e_wdata = m_wdata(wr, f3, data);
    if (!go) begin
      e_req = 0; e_stall = 0;
      dmem_ready = 1'($urandom); dmem_rvalid = 1'($urandom); dmem_rdata = $urandom;
      step();
      return;
    end
    e_req = 1;
    for (int i = 0; i < rdy_dly; i++) begin
      dmem_ready = 0; dmem_rvalid = 1'($urandom); dmem_rdata = $urandom;
      e_stall = 1;
      step();
    end
    dmem_ready = 1; dmem_rvalid = 1'($urandom); dmem_rdata = $urandom;
    e_stall = rd;
    step();
    if (rd) begin
      e_req = 0;
      for (int j = 1; j <= rv_dly; j++) begin
        dmem_ready  = 1'($urandom);
        dmem_rvalid = (j == rv_dly);
        dmem_rdata  = (j == rv_dly) ? rdata : $urandom;
        e_stall     = (j != rv_dly);
        step();
      end
    end
    dmem_ready = 0; dmem_rvalid = 0;
  endtask

  task automatic nop();
    do_op(0, 0, 3'd0, $urandom, $urandom, 0, 0, 0, 5'($urandom), 0, 1'($urandom));
  endtask

  initial begin
    rst = 1;
    me_alu_o = 0; me_regs_data2 = 0; me_rd = 0; me_mem_read = 0; me_mem_write = 0;
    me_mem2reg = 0; me_regs_write = 0; me_func3_code = 0;
    dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = 0;
    e_req = 0; e_stall = 0; e_we = 0; e_addr = 0; e_be = 0; e_wdata = 0;
    cur_mis = 0;
    m_alu = 0; m_ld = 0; m_rd = 0; m_m2r = 0; m_rw = 0; m_exc = 0;
    stall_cnt = 0; req_cnt = 0; seen_be = 0; seen_wdata = 0;
    step(); step();
    rst = 0;
    chk_en = 1; chk_ctl = 1;
    check("reset_wb_regs_write", {31'b0, wb_regs_write}, 32'd0);
    check("reset_wb_alu_o", wb_alu_o, 32'd0);
    nop();

    // SW 0x100 <- DEADBEEF, zero-wait
    stall_cnt = 0; req_cnt = 0;
    do_op(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0, 5'd0, 0, 0);
    check("sw_stall_cycles", stall_cnt, 0);
    check("sw_req_cycles", req_cnt, 1);
    check("sw_be", {28'b0, seen_be}, 32'hF);
    check("sw_wdata", seen_wdata, 32'hDEADBEEF);

    // LB 0x103, rvalid one cycle after accept
    stall_cnt = 0; req_cnt = 0;
    do_op(1, 0, 3'b000, 32'h103, 0, 0, 1, 32'h80FF1234, 5'd7, 1, 1);
    check("lb_stall_cycles", stall_cnt, 1);
    check("lb_model", m_ld, 32'hFFFFFF80);
    check("lb_wb_load_data", wb_load_data, 32'hFFFFFF80);

    // LHU 0x202, ready low 3 cycles, rvalid 2 cycles after accept
    stall_cnt = 0; req_cnt = 0;
    do_op(1, 0, 3'b101, 32'h202, 0, 3, 2, 32'hABCD0000, 5'd9, 1, 1);
    check("lhu_stall_cycles", stall_cnt, 5);
    check("lhu_req_cycles", req_cnt, 4);
    check("lhu_model", m_ld, 32'h0000ABCD);
    check("lhu_wb_load_data", wb_load_data, 32'h0000ABCD);

    // LW 0x101 misaligned
    stall_cnt = 0; req_cnt = 0;
    do_op(1, 0, 3'b010, 32'h101, 0, 0, 1, 0, 5'd3, 1, 1);
    check("lw_mis_req_cycles", req_cnt, 0);
    check("lw_mis_stall_cycles", stall_cnt, 0);
    check("lw_mis_exc", {31'b0, wb_mem_exc}, 32'd1);
    check("lw_mis_regs_write", {31'b0, wb_regs_write}, 32'd0);

    // SB 0x002 <- 0x55
    do_op(0, 1, 3'b000, 32'h002, 32'h55, 0, 0, 0, 5'd0, 0, 0);
    check("sb_be", {28'b0, seen_be}, 32'h4);
    check("sb_wdata", seen_wdata, 32'h55555555);

    // Reset while waiting for a load response, then a stray rvalid
    me_mem_read = 1; me_mem_write = 0; me_func3_code = 3'b010; me_alu_o = 32'h300;
    me_regs_data2 = 0; me_rd = 5'd4; me_mem2reg = 1; me_regs_write = 1; cur_mis = 0;
    e_req = 1; e_stall = 1; e_we = 0; e_addr = 32'h300; e_be = 4'hF; e_wdata = 0;
    dmem_ready = 1; dmem_rvalid = 0;
    step();
    rst = 1; chk_ctl = 0; dmem_ready = 0;
    step();
    rst = 0; chk_ctl = 1;
    me_mem_read = 0; me_regs_write = 0; me_mem2reg = 0;
    dmem_rvalid = 1; dmem_rdata = 32'h12345678;
    e_req = 0; e_stall = 0;
    step();
    check("rst_resp_regs_write", {31'b0, wb_regs_write}, 32'd0);
    dmem_rvalid = 0;
    nop();

    // Randomized traffic
    for (int k = 0; k < 200; k++) begin
      int kind;
      logic [2:0] f3;
      logic [31:0] a;
      kind = $urandom_range(0, 9);
      a = ($urandom & 32'h0000_FFFC) | 32'($urandom_range(0, 3));
      if (kind < 2) begin
        nop();
      end else if (kind < 6) begin
        f3 = 3'($urandom_range(0, 7));
        do_op(1, 0, f3, a, $urandom, $urandom_range(0, 3), $urandom_range(1, 3),
              $urandom, 5'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        f3 = 3'($urandom_range(0, 3));
        do_op(0, 1, f3, a, $urandom, $urandom_range(0, 3), 0,
              0, 5'($urandom), 1'($urandom), 1'($urandom));
      end
    end

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d expected to complete", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
